// File: rtl/irq_vector_ctrl.sv
// rtl/irq_vector_ctrl.sv - fixed-priority nested interrupt controller with ISR entry vectoring
module irq_vector_ctrl #(
    parameter int NIRQ        = 3,
    parameter int NBIT_IRQ    = 2,
    parameter int ADDR_NBIT   = 10,
    parameter int ENTR_BASE   = 'h123,
    parameter int ENTR_STRIDE = 'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NIRQ-1:0]      irq_src,
    input  logic [NIRQ-1:0]      irq_mask,
    input  logic                 glb_en,
    input  logic                 irq_ack,
    input  logic                 irq_ret,
    output logic                 irq_req,
    output logic [NBIT_IRQ-1:0]  irq_num,
    output logic [ADDR_NBIT-1:0] irq_entr,
    output logic [NIRQ-1:0]      pending,
    output logic [NIRQ-1:0]      in_service
);

    logic [NIRQ-1:0]      src_q, pending_q, pending_d, in_service_q, in_service_d;
    logic                 irq_req_q, irq_req_d;
    logic [NBIT_IRQ-1:0]  irq_num_q, irq_num_d;
    logic [ADDR_NBIT-1:0] irq_entr_q, irq_entr_d;

    logic [NIRQ-1:0]      edges, grant_oh, ret_oh, eligible;
    logic                 grant;
    logic [NBIT_IRQ-1:0]  cand, isv_idx;

    function automatic logic [NBIT_IRQ-1:0] lowest_idx(input logic [NIRQ-1:0] v);
        logic [NBIT_IRQ-1:0] idx;
        idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = NBIT_IRQ'(i);
        end
        return idx;
    endfunction

    always_comb begin
        edges = irq_src & ~src_q;
        grant = irq_ack & irq_req_q;

        grant_oh = '0;
        if (grant) begin
            for (int i = 0; i < NIRQ; i++) grant_oh[i] = (irq_num_q == NBIT_IRQ'(i));
        end

        // Returning always closes the highest-priority (innermost) active ISR
        ret_oh = '0;
        if (irq_ret) ret_oh = in_service_q & (~in_service_q + NIRQ'(1));

        pending_d    = ((pending_q | edges) & ~grant_oh) | edges;
        in_service_d = (in_service_q & ~ret_oh) | grant_oh;

        eligible = pending_d & irq_mask;
        cand     = lowest_idx(eligible);
        isv_idx  = lowest_idx(in_service_d);

        irq_req_d  = glb_en & (|eligible) & (~(|in_service_d) | (cand < isv_idx));
        irq_num_d  = irq_req_d ? cand : '0;
        irq_entr_d = irq_req_d ? ADDR_NBIT'(ENTR_BASE + int'(cand) * ENTR_STRIDE) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            irq_req_q    <= 1'b0;
            irq_num_q    <= '0;
            irq_entr_q   <= '0;
        end else begin
            src_q        <= irq_src;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irq_req_q    <= irq_req_d;
            irq_num_q    <= irq_num_d;
            irq_entr_q   <= irq_entr_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_num    = irq_num_q;
    assign irq_entr   = irq_entr_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// tb/tb_irq_vector_ctrl.sv - directed and randomized bench for irq_vector_ctrl
module tb_irq_vector_ctrl;

    localparam int NIRQ        = 3;
    localparam int NBIT_IRQ    = 2;
    localparam int ADDR_NBIT   = 10;
    localparam int ENTR_BASE   = 'h123;
    localparam int ENTR_STRIDE = 'h20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NIRQ-1:0]      irq_src, irq_mask;
    logic                 glb_en, irq_ack, irq_ret;
    logic                 irq_req;
    logic [NBIT_IRQ-1:0]  irq_num;
    logic [ADDR_NBIT-1:0] irq_entr;
    logic [NIRQ-1:0]      pending, in_service;

    int checks = 0;
    int errors = 0;

    bit pend_m [NIRQ];
    bit insv_m [NIRQ];
    bit prev_m [NIRQ];
    bit req_m;
    int num_m, entr_m;

    irq_vector_ctrl #(
        .NIRQ(NIRQ), .NBIT_IRQ(NBIT_IRQ), .ADDR_NBIT(ADDR_NBIT),
        .ENTR_BASE(ENTR_BASE), .ENTR_STRIDE(ENTR_STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .irq_mask(irq_mask),
        .glb_en(glb_en), .irq_ack(irq_ack), .irq_ret(irq_ret),
        .irq_req(irq_req), .irq_num(irq_num), .irq_entr(irq_entr),
        .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pack(input bit a [NIRQ]);
        int v = 0;
        for (int i = 0; i < NIRQ; i++) if (a[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NIRQ; i++) begin
            pend_m[i] = 0; insv_m[i] = 0; prev_m[i] = 0;
        end
        req_m = 0; num_m = 0; entr_m = 0;
    endtask

    // Reference: sets of pending/active channels and "smallest index wins" searches
    task automatic model_step();
        bit grant;
        int active, cand;
        grant = irq_ack && req_m;
        if (grant) pend_m[num_m] = 0;
        for (int i = 0; i < NIRQ; i++) if (irq_src[i] && !prev_m[i]) pend_m[i] = 1;
        if (irq_ret) begin
            for (int i = 0; i < NIRQ; i++) if (insv_m[i]) begin insv_m[i] = 0; break; end
        end
        if (grant) insv_m[num_m] = 1;
        active = NIRQ;
        for (int i = 0; i < NIRQ; i++) if (insv_m[i]) begin active = i; break; end
        cand = -1;
        for (int i = 0; i < NIRQ; i++) if (pend_m[i] && irq_mask[i]) begin cand = i; break; end
        req_m  = glb_en && cand >= 0 && cand < active;
        num_m  = req_m ? cand : 0;
        entr_m = req_m ? (ENTR_BASE + cand * ENTR_STRIDE) % (1 << ADDR_NBIT) : 0;
        for (int i = 0; i < NIRQ; i++) prev_m[i] = irq_src[i];
    endtask

    task automatic check_all();
        chk("pending", 32'(pending), pack(pend_m));
        chk("in_service", 32'(in_service), pack(insv_m));
        chk("irq_req", 32'(irq_req), 32'(req_m));
        chk("irq_num", 32'(irq_num), num_m);
        chk("irq_entr", 32'(irq_entr), entr_m);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; irq_mask = '1; glb_en = 1'b1; irq_ack = 1'b0; irq_ret = 1'b0;
        model_reset();
        #2;
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_insv", 32'(in_service), 0);
        chk("rst_entr", 32'(irq_entr), 0);
        cyc();
        rst = 1'b0;
        cyc();

        irq_src = 3'b010; cyc(); irq_src = '0;
        chk("t1_pending", 32'(pending), 3'b010);
        chk("t1_req", 32'(irq_req), 1);
        chk("t1_num", 32'(irq_num), 1);
        chk("t1_entr", 32'(irq_entr), 'h143);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        irq_ret = 1'b1; cyc(); irq_ret = 1'b0;
        chk("t1_idle", 32'(in_service), 0);

        irq_src = 3'b101; cyc(); irq_src = '0;
        chk("t2_num", 32'(irq_num), 0);
        chk("t2_entr", 32'(irq_entr), 'h123);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("t2_insv", 32'(in_service), 3'b001);
        chk("t2_blocked", 32'(irq_req), 0);
        irq_ret = 1'b1; cyc(); irq_ret = 1'b0;
        chk("t2_ret_req", 32'(irq_req), 1);
        chk("t2_ret_num", 32'(irq_num), 2);
        chk("t2_ret_entr", 32'(irq_entr), 'h163);

        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("t3_insv", 32'(in_service), 3'b100);
        irq_src = 3'b001; cyc(); irq_src = '0;
        chk("t3_preempt_req", 32'(irq_req), 1);
        chk("t3_preempt_num", 32'(irq_num), 0);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("t3_nested", 32'(in_service), 3'b101);
        irq_ret = 1'b1; cyc();
        chk("t3_ret1", 32'(in_service), 3'b100);
        cyc(); irq_ret = 1'b0;
        chk("t3_ret2", 32'(in_service), 0);

        glb_en = 1'b0; irq_src = 3'b010; cyc(); irq_src = '0;
        chk("t4_pending", 32'(pending), 3'b010);
        chk("t4_req_off", 32'(irq_req), 0);
        glb_en = 1'b1; cyc();
        chk("t4_req_on", 32'(irq_req), 1);
        chk("t4_num", 32'(irq_num), 1);

        irq_ack = 1'b1; irq_src = 3'b010; cyc(); irq_ack = 1'b0; irq_src = '0;
        chk("t5_pending", 32'(pending[1]), 1);
        chk("t5_insv", 32'(in_service), 3'b010);
        chk("t5_blocked", 32'(irq_req), 0);
        irq_ret = 1'b1; cyc(); irq_ret = 1'b0;
        chk("t5_req", 32'(irq_req), 1);
        chk("t5_num", 32'(irq_num), 1);

        for (int n = 0; n < 400; n++) begin
            irq_src  = NIRQ'($urandom);
            irq_mask = ($urandom_range(0, 7) == 0) ? NIRQ'($urandom) : '1;
            glb_en   = ($urandom_range(0, 9) != 0);
            irq_ack  = ($urandom_range(0, 2) == 0);
            irq_ret  = ($urandom_range(0, 5) == 0);
            cyc();
        end

        irq_src = '0; irq_mask = '1; glb_en = 1'b1; irq_ack = 1'b0; irq_ret = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        irq_src = 3'b010; cyc(); irq_src = '0;
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        irq_src = 3'b100; cyc(); irq_src = '0;
        chk("t6_insv", 32'(in_service), 3'b010);
        chk("t6_pending", 32'(pending), 3'b100);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
